// File: rtl/axis32_rx_frame_fifo_pkg.sv
// ---------------------------------------------------------------------------
// axis32_rx_frame_fifo_pkg
//    Shared definitions for the store-and-forward RX frame FIFO:
//    - VLDB_1B..VLDB_4B : encodings of the tvldb field.
//    - wr_state_t       : one-hot encodings of the write-side states.
//    - ENTRY_W and the *_LSB/*_BIT offsets : layout of one RAM word
//      (data32 + vldb2 + last + user).
//    - entry_t          : packed view of one RAM word, matching the offsets.
//    - pack_entry()     : builds a RAM word from the individual fields.
// ---------------------------------------------------------------------------
package axis32_rx_frame_fifo_pkg;

   localparam logic [1:0] VLDB_1B = 2'd0;
   localparam logic [1:0] VLDB_2B = 2'd1;
   localparam logic [1:0] VLDB_3B = 2'd2;
   localparam logic [1:0] VLDB_4B = 2'd3;

   typedef enum logic [2:0] {
      W_IDLE    = 3'b001,
      W_FRAME   = 3'b010,
      W_DISCARD = 3'b100
   } wr_state_t;

   localparam int ENTRY_W  = 36;
   localparam int DATA_LSB = 0;
   localparam int VLDB_LSB = 32;
   localparam int LAST_BIT = 34;
   localparam int USER_BIT = 35;

   // Field order must mirror the offsets above (MSB first).
   typedef struct packed {
      logic        user;
      logic        last;
      logic [1:0]  vldb;
      logic [31:0] data;
   } entry_t;

   function automatic logic [ENTRY_W-1:0] pack_entry(
      input logic [31:0] data,
      input logic [1:0]  vldb,
      input logic        last,
      input logic        user
   );
      logic [ENTRY_W-1:0] e;
      e                    = '0;
      e[DATA_LSB +: 32]    = data;
      e[VLDB_LSB +: 2]     = vldb;
      e[LAST_BIT]          = last;
      e[USER_BIT]          = user;
      return e;
   endfunction

endpackage

// File: rtl/axis32_fifo_sdp_ram.sv
// ---------------------------------------------------------------------------
// axis32_fifo_sdp_ram
//    Simple dual-port RAM, ENTRY_W bits x 2^ADDR_W words, one write port and
//    one read port with a registered output (1-cycle read latency).
//    Ports:
//       clk_i     : sole clock
//       wr_en     : write strobe
//       wr_addr   : write address
//       wr_data   : write word
//       rd_en     : read strobe; rd_data updates on the next edge
//       rd_addr   : read address
//       rd_data   : registered read word
// ---------------------------------------------------------------------------
module axis32_fifo_sdp_ram
   import axis32_rx_frame_fifo_pkg::*;
#(
   parameter int ADDR_W = 11
) (
   input  logic               clk_i,
   input  logic               wr_en,
   input  logic [ADDR_W-1:0]  wr_addr,
   input  logic [ENTRY_W-1:0] wr_data,
   input  logic               rd_en,
   input  logic [ADDR_W-1:0]  rd_addr,
   output logic [ENTRY_W-1:0] rd_data
);

   logic [ENTRY_W-1:0] mem [2**ADDR_W];

   // Memory array and output register carry no reset so the array can map
   // onto block RAM; the consumer qualifies rd_data with its own valid flag.
   always_ff @(posedge clk_i) begin
      if (wr_en) begin
         mem[wr_addr] <= wr_data;
      end
      if (rd_en) begin
         rd_data <= mem[rd_addr];
      end
   end

endmodule

// File: rtl/axis32_rx_frame_fifo.sv
// ---------------------------------------------------------------------------
// axis32_rx_frame_fifo
//    Store-and-forward RX frame FIFO. Accepts 32-bit AXIS beats without
//    backpressure, buffers whole frames, drops frames that do not fit and
//    releases only complete frames on a tready/tvalid AXIS master port.
//
//    Build option:
//       RX_FIFO_DROP_BAD_EN defined   : frames ending with tuser=0 are dropped.
//       RX_FIFO_DROP_BAD_EN undefined : such frames are stored and forwarded
//                                       with m_tuser_o=0 on their last beat.
//       bad_frames_o counts them in both builds.
//
//    Ports:
//       clk_i, rst_n_i        : clock, synchronous active-low reset
//       s_tdata/tvldb/tvalid/tlast/tuser_i : receive beat stream (no tready)
//       m_tdata/tvldb/tvalid/tlast/tuser_o, m_tready_i : AXIS master output
//       bad_frames_o          : frames ending with tuser=0
//       ovf_frames_o          : frames dropped for lack of space
// ---------------------------------------------------------------------------
module axis32_rx_frame_fifo
   import axis32_rx_frame_fifo_pkg::*;
#(
   parameter int ADDR_W = 11
) (
   input  logic        clk_i,
   input  logic        rst_n_i,
   input  logic [31:0] s_tdata_i,
   input  logic [1:0]  s_tvldb_i,
   input  logic        s_tvalid_i,
   input  logic        s_tlast_i,
   input  logic        s_tuser_i,
   output logic [31:0] m_tdata_o,
   output logic [1:0]  m_tvldb_o,
   output logic        m_tvalid_o,
   input  logic        m_tready_i,
   output logic        m_tlast_o,
   output logic        m_tuser_o,
   output logic [31:0] bad_frames_o,
   output logic [31:0] ovf_frames_o
);

`ifdef RX_FIFO_DROP_BAD_EN
   localparam bit DROP_BAD_EN = 1'b1;
`else
   localparam bit DROP_BAD_EN = 1'b0;
`endif

   localparam logic [ADDR_W-1:0] PTR_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};

   wr_state_t          state;
   wr_state_t          next_state;
   logic [ADDR_W-1:0]  wr_ptr;
   logic [ADDR_W-1:0]  wr_commit;
   logic [ADDR_W-1:0]  rd_ptr;
   logic               full;
   logic               do_write;
   logic               do_commit;
   logic               do_rollback;
   logic               inc_ovf;
   logic               inc_bad;
   logic [ENTRY_W-1:0] ram_wdata;
   logic [ENTRY_W-1:0] ram_rdata;
   logic               rd_issue;
   logic               rd_pend;
   logic [1:0]         skid_cnt;
   logic [1:0]         skid_occ;
   logic               pop;
   entry_t             skid0;
   entry_t             skid1;
   entry_t             ram_entry;

   // Full compares against the registered rd_ptr, so an entry freed by a read
   // only becomes usable one cycle later.
   assign full = ((wr_ptr + PTR_ONE) == rd_ptr);

   // Every frame whose last beat reports a bad FCS is counted, whatever
   // happens to it afterwards.
   assign inc_bad = s_tvalid_i & s_tlast_i & ~s_tuser_i;

   // The user bit is only meaningful on the last beat; store 0 elsewhere.
   assign ram_wdata = pack_entry(s_tdata_i, s_tvldb_i, s_tlast_i,
                                 s_tlast_i & s_tuser_i);

   // Write FSM state register.
   always_ff @(posedge clk_i) begin
      if (!rst_n_i) begin
         state <= W_IDLE;
      end else begin
         state <= next_state;
      end
   end

   // Write FSM next state. W_IDLE and W_FRAME handle a beat identically: a
   // first beat that also carries tlast resolves as a complete frame.
   always_comb begin
      next_state = state;
      case (state)
         W_IDLE, W_FRAME: begin
            if (s_tvalid_i) begin
               if (s_tlast_i) begin
                  next_state = W_IDLE;
               end else if (full) begin
                  next_state = W_DISCARD;
               end else begin
                  next_state = W_FRAME;
               end
            end
         end
         W_DISCARD: begin
            if (s_tvalid_i && s_tlast_i) begin
               next_state = W_IDLE;
            end
         end
         default: next_state = W_IDLE;
      endcase
   end

   // Write FSM actions. A beat arriving while full drops the whole frame by
   // rewinding wr_ptr to the last commit point; so does a bad tlast when
   // bad frames are dropped.
   always_comb begin
      do_write    = 1'b0;
      do_commit   = 1'b0;
      do_rollback = 1'b0;
      inc_ovf     = 1'b0;
      case (state)
         W_IDLE, W_FRAME: begin
            if (s_tvalid_i) begin
               if (full) begin
                  inc_ovf     = 1'b1;
                  do_rollback = 1'b1;
               end else if (s_tlast_i && !s_tuser_i && DROP_BAD_EN) begin
                  do_rollback = 1'b1;
               end else begin
                  do_write  = 1'b1;
                  do_commit = s_tlast_i;
               end
            end
         end
         default: begin
         end
      endcase
   end

   // Write pointers and statistics counters.
   always_ff @(posedge clk_i) begin
      if (!rst_n_i) begin
         wr_ptr       <= '0;
         wr_commit    <= '0;
         bad_frames_o <= '0;
         ovf_frames_o <= '0;
      end else begin
         if (do_write) begin
            wr_ptr <= wr_ptr + PTR_ONE;
         end
         if (do_rollback) begin
            wr_ptr <= wr_commit;
         end
         if (do_commit) begin
            wr_commit <= wr_ptr + PTR_ONE;
         end
         if (inc_ovf) begin
            ovf_frames_o <= ovf_frames_o + 32'd1;
         end
         if (inc_bad) begin
            bad_frames_o <= bad_frames_o + 32'd1;
         end
      end
   end

   axis32_fifo_sdp_ram #(
      .ADDR_W (ADDR_W)
   ) u_ram (
      .clk_i   (clk_i),
      .wr_en   (do_write),
      .wr_addr (wr_ptr),
      .wr_data (ram_wdata),
      .rd_en   (rd_issue),
      .rd_addr (rd_ptr),
      .rd_data (ram_rdata)
   );

   // A read is issued only if the skid will still have a free slot when the
   // data lands: beats held plus the read in flight, minus the beat leaving
   // now. This keeps 1 beat/clk flowing with m_tready_i held high.
   assign pop      = (skid_cnt != 2'd0) && m_tready_i;
   assign skid_occ = skid_cnt + {1'b0, rd_pend};
   assign rd_issue = (rd_ptr != wr_commit) &&
                     ((skid_occ - {1'b0, pop}) <= 2'd1);
   assign ram_entry = entry_t'(ram_rdata);

   // Read pointer, read-in-flight flag and the 2-entry output skid. skid0 is
   // always the beat presented on the m_* outputs.
   always_ff @(posedge clk_i) begin
      if (!rst_n_i) begin
         rd_ptr   <= '0;
         rd_pend  <= 1'b0;
         skid_cnt <= 2'd0;
         skid0    <= '0;
         skid1    <= '0;
      end else begin
         rd_pend <= rd_issue;
         if (rd_issue) begin
            rd_ptr <= rd_ptr + PTR_ONE;
         end
         if (rd_pend && !pop) begin
            if (skid_cnt == 2'd0) begin
               skid0 <= ram_entry;
            end else begin
               skid1 <= ram_entry;
            end
            skid_cnt <= skid_cnt + 2'd1;
         end else if (!rd_pend && pop) begin
            skid0    <= skid1;
            skid_cnt <= skid_cnt - 2'd1;
         end else if (rd_pend && pop) begin
            if (skid_cnt == 2'd1) begin
               skid0 <= ram_entry;
            end else begin
               skid0 <= skid1;
               skid1 <= ram_entry;
            end
         end
      end
   end

   assign m_tvalid_o = (skid_cnt != 2'd0);
   assign m_tdata_o  = skid0.data;
   assign m_tvldb_o  = skid0.vldb;
   assign m_tlast_o  = skid0.last;
   assign m_tuser_o  = skid0.user;

endmodule

// File: tb/tb_axis32_rx_frame_fifo.sv
// ---------------------------------------------------------------------------
// tb_axis32_rx_frame_fifo
//    Self-checking bench for axis32_rx_frame_fifo (ADDR_W=5, 31 usable words).
//    Follows the RX_FIFO_DROP_BAD_EN build option of the design.
// ---------------------------------------------------------------------------
module tb_axis32_rx_frame_fifo;

   localparam int ADDR_W = 5;
   localparam int CAP    = (1 << ADDR_W) - 1;

`ifdef RX_FIFO_DROP_BAD_EN
   localparam bit DROP_BAD = 1'b1;
`else
   localparam bit DROP_BAD = 1'b0;
`endif

   logic        clk;
   logic        rst_n;
   logic [31:0] s_tdata;
   logic [1:0]  s_tvldb;
   logic        s_tvalid;
   logic        s_tlast;
   logic        s_tuser;
   logic [31:0] m_tdata;
   logic [1:0]  m_tvldb;
   logic        m_tvalid;
   logic        m_tready;
   logic        m_tlast;
   logic        m_tuser;
   logic [31:0] bad_frames;
   logic [31:0] ovf_frames;

   typedef struct {
      logic [31:0] data;
      logic [1:0]  vldb;
      logic        last;
      logic        user;
   } beat_t;

   typedef struct {
      int         len;
      logic [1:0] vldb;
      logic       good;
      bit         fits;
      int         gap_pct;
      int         exp_beats;
      int         exp_bad;
      int         exp_ovf;
   } vec_t;

   beat_t exp_q[$];
   vec_t  vecs[9];
   int    total_checks = 0;
   int    fail_checks  = 0;
   int    rx_count     = 0;
   int    exp_bad      = 0;
   int    exp_ovf      = 0;
   int    rdy_mode     = 1;
   bit    prev_stall   = 1'b0;

   axis32_rx_frame_fifo #(
      .ADDR_W (ADDR_W)
   ) dut (
      .clk_i        (clk),
      .rst_n_i      (rst_n),
      .s_tdata_i    (s_tdata),
      .s_tvldb_i    (s_tvldb),
      .s_tvalid_i   (s_tvalid),
      .s_tlast_i    (s_tlast),
      .s_tuser_i    (s_tuser),
      .m_tdata_o    (m_tdata),
      .m_tvldb_o    (m_tvldb),
      .m_tvalid_o   (m_tvalid),
      .m_tready_i   (m_tready),
      .m_tlast_o    (m_tlast),
      .m_tuser_o    (m_tuser),
      .bad_frames_o (bad_frames),
      .ovf_frames_o (ovf_frames)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic checkOutput(input string name, input logic [63:0] act,
                              input logic [63:0] exp);
      total_checks++;
      if (act !== exp) begin
         fail_checks++;
         $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   // Sends one frame starting at posedge+1. abort_at>0 stops after that many
   // beats without touching the model (used for the reset test).
   task automatic applyStimulus(input int len, input logic [1:0] last_vldb,
                                input logic good, input bit fits,
                                input int gap_pct, input int abort_at);
      beat_t frame[$];
      beat_t b;
      for (int i = 0; i < len; i++) begin
         if (abort_at > 0 && i == abort_at) begin
            s_tvalid = 1'b0;
            return;
         end
         while ($urandom_range(0, 99) < gap_pct) begin
            s_tvalid = 1'b0;
            s_tdata  = $urandom;
            s_tlast  = $urandom_range(0, 1);
            s_tuser  = $urandom_range(0, 1);
            s_tvldb  = $urandom_range(0, 3);
            tick(1);
         end
         b.data = $urandom;
         b.last = (i == len - 1);
         b.vldb = b.last ? last_vldb : 2'd3;
         b.user = good;
         s_tvalid = 1'b1;
         s_tdata  = b.data;
         s_tvldb  = b.vldb;
         s_tlast  = b.last;
         s_tuser  = b.last ? good : logic'($urandom_range(0, 1));
         frame.push_back(b);
         tick(1);
      end
      s_tvalid = 1'b0;
      s_tlast  = 1'b0;
      if (!good) exp_bad++;
      if (!fits) begin
         exp_ovf++;
      end else if (good || !DROP_BAD) begin
         foreach (frame[k]) exp_q.push_back(frame[k]);
      end
   endtask

   task automatic waitDrain(input string name);
      int cyc = 0;
      while (exp_q.size() != 0 && cyc < 3000) begin
         tick(1);
         cyc++;
      end
      checkOutput({name, "_drained"}, exp_q.size(), 0);
      tick(4);
   endtask

   // Downstream ready: 0 = held low, 1 = held high, 2 = random 50%.
   initial begin
      m_tready = 1'b1;
      forever begin
         @(posedge clk);
         #1;
         case (rdy_mode)
            0:       m_tready = 1'b0;
            1:       m_tready = 1'b1;
            default: m_tready = logic'($urandom_range(0, 1));
         endcase
      end
   end

   // Output monitor: every presented beat must equal the next expected beat,
   // whether or not it is accepted, and tvalid may not drop while stalled.
   initial begin
      beat_t e;
      forever begin
         @(negedge clk);
         if (rst_n === 1'b1) begin
            if (prev_stall) checkOutput("valid_hold", m_tvalid, 1);
            if (m_tvalid === 1'b1) begin
               if (exp_q.size() == 0) begin
                  checkOutput("unexpected_beat", {m_tdata, m_tvldb, m_tlast}, 0);
               end else begin
                  e = exp_q[0];
                  checkOutput("beat",
                     {m_tdata, m_tvldb, m_tlast, m_tlast & m_tuser},
                     {e.data, e.vldb, e.last, e.last & e.user});
                  if (m_tready === 1'b1) begin
                     void'(exp_q.pop_front());
                     rx_count++;
                  end
               end
            end
            prev_stall = (m_tvalid === 1'b1) && (m_tready !== 1'b1);
         end else begin
            prev_stall = 1'b0;
         end
      end
   end

   initial begin
      #600000;
      $display("[TB] FAIL watchdog: simulation did not complete");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      int rx0;
      int len;
      int cyc;
      logic good;
      bit fits;

      vecs[0] = '{16, 2'd3, 1'b1, 1'b1,  0, 16,               0, 0};
      vecs[1] = '{20, 2'd3, 1'b0, 1'b1, 20, DROP_BAD ? 0 : 20, 1, 0};
      vecs[2] = '{17, 2'd0, 1'b1, 1'b1, 20, 17,               1, 0};
      vecs[3] = '{ 8, 2'd2, 1'b0, 1'b1,  0, DROP_BAD ? 0 : 8,  2, 0};
      vecs[4] = '{ 1, 2'd1, 1'b1, 1'b1,  0, 1,                2, 0};
      vecs[5] = '{ 1, 2'd3, 1'b0, 1'b1,  0, DROP_BAD ? 0 : 1,  3, 0};
      vecs[6] = '{31, 2'd3, 1'b1, 1'b1,  0, 31,               3, 0};
      vecs[7] = '{32, 2'd3, 1'b1, 1'b0,  0, 0,                3, 1};
      vecs[8] = '{ 3, 2'd2, 1'b1, 1'b1, 30, 3,                3, 1};

      rst_n    = 1'b0;
      s_tvalid = 1'b0;
      s_tdata  = '0;
      s_tvldb  = '0;
      s_tlast  = 1'b0;
      s_tuser  = 1'b0;
      rdy_mode = 1;
      tick(3);
      checkOutput("reset_outputs", {m_tvalid, m_tdata, m_tvldb, m_tlast, m_tuser}, 0);
      checkOutput("reset_counters", {bad_frames, ovf_frames}, 0);
      rst_n = 1'b1;
      tick(2);

      // Directed frames with tready held high.
      for (int v = 0; v < 9; v++) begin
         rx0 = rx_count;
         applyStimulus(vecs[v].len, vecs[v].vldb, vecs[v].good, vecs[v].fits,
                       vecs[v].gap_pct, 0);
         waitDrain($sformatf("vec%0d", v));
         checkOutput($sformatf("vec%0d_beats", v), rx_count - rx0, vecs[v].exp_beats);
         checkOutput($sformatf("vec%0d_bad", v), bad_frames, vecs[v].exp_bad);
         checkOutput($sformatf("vec%0d_ovf", v), ovf_frames, vecs[v].exp_ovf);
      end

      // Stalled output: the second 20-beat frame cannot fit.
      rdy_mode = 0;
      tick(1);
      applyStimulus(20, 2'd3, 1'b1, 1'b1, 0, 0);
      applyStimulus(20, 2'd3, 1'b1, 1'b0, 0, 0);
      tick(10);
      checkOutput("stall_ovf", ovf_frames, exp_ovf);
      checkOutput("stall_valid", m_tvalid, 1);
      rx0 = rx_count;
      rdy_mode = 1;
      waitDrain("stall");
      checkOutput("stall_beats", rx_count - rx0, 20);
      checkOutput("stall_idle", m_tvalid, 0);

      // Random frames, random gaps, random ready. A frame that fits is only
      // sent once the bench-side backlog guarantees room for it.
      rdy_mode = 2;
      for (int f = 0; f < 100; f++) begin
         len  = $urandom_range(1, 40);
         good = ($urandom_range(0, 4) != 0);
         fits = (len <= CAP);
         if (!fits) good = 1'b1;
         if (fits) begin
            cyc = 0;
            while (exp_q.size() + len > CAP && cyc < 3000) begin
               tick(1);
               cyc++;
            end
            checkOutput("room_wait", cyc < 3000, 1);
         end
         applyStimulus(len, 2'($urandom_range(0, 3)), good, fits, 30, 0);
      end
      rdy_mode = 1;
      waitDrain("random");
      checkOutput("random_bad", bad_frames, exp_bad);
      checkOutput("random_ovf", ovf_frames, exp_ovf);

      // Reset with one frame queued and another half written.
      rdy_mode = 0;
      tick(1);
      applyStimulus(5, 2'd3, 1'b1, 1'b1, 0, 0);
      applyStimulus(12, 2'd3, 1'b1, 1'b1, 0, 5);
      rst_n = 1'b0;
      tick(1);
      exp_q.delete();
      exp_bad = 0;
      exp_ovf = 0;
      checkOutput("rst_mid_outputs", {m_tvalid, m_tdata, m_tvldb, m_tlast, m_tuser}, 0);
      checkOutput("rst_mid_counters", {bad_frames, ovf_frames}, 0);
      tick(1);
      rst_n = 1'b1;
      rdy_mode = 1;
      tick(4);
      checkOutput("rst_no_stale", m_tvalid, 0);
      rx0 = rx_count;
      applyStimulus(6, 2'd2, 1'b1, 1'b1, 0, 0);
      waitDrain("post_rst");
      checkOutput("post_rst_beats", rx_count - rx0, 6);
      checkOutput("post_rst_counters", {bad_frames, ovf_frames}, 0);

      $display("test done: total=%0d bad=%0d", total_checks, fail_checks);
      $finish;
   end

endmodule
